// File: rtl/iis_receiver.sv
// IIS (I2S) serial receiver with a small receive FIFO and sticky error flags.
// Ports:
//   pclk, presetn          system clock, async active-low reset
//   enable                 receiver enable (0 holds the receiver idle)
//   bclk, lrck, sdata      IIS serial inputs, asynchronous to pclk
//   rdreq                  pop request
//   rdata, rchan, rvalid   popped sample, its channel, one-cycle valid pulse
//   empty, full, level     FIFO status
//   overrun, frame_err     sticky error flags, cleared by clr_err
module iis_receiver #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          enable,
    input  logic                          bclk,
    input  logic                          lrck,
    input  logic                          sdata,
    input  logic                          rdreq,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rchan,
    output logic                          rvalid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic bclk_s1, bclk_s2, bclk_h;
    logic lrck_s1, lrck_s2;
    logic sdata_s1, sdata_s2;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bclk_s1  <= 1'b0;
            bclk_s2  <= 1'b0;
            bclk_h   <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            bclk_s1  <= bclk;
            bclk_s2  <= bclk_s1;
            bclk_h   <= bclk_s2;
            lrck_s1  <= lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
        end
    end

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                chan;
    logic [DATA_W-1:0]   sr;
    logic                lrck_prev;
    // lrck_prev is meaningless until one rise has been sampled; without
    // this a reset in the middle of a right slot would look like a ws change.
    logic                lr_seen;

    logic                rise;
    logic                ws_chg;
    logic                in_shift;
    logic                push_now;
    logic                ferr_now;
    logic [DATA_W-1:0]   word_now;

    assign rise     = bclk_s2 & ~bclk_h;
    assign ws_chg   = rise & lr_seen & (lrck_s2 != lrck_prev);
    assign in_shift = enable & (state == SHIFT) & rise;
    assign push_now = in_shift & (cnt == CNT_LAST);
    // A ws change that leaves the word short of DATA_W bits is a framing error.
    assign ferr_now = in_shift & ws_chg & (cnt < CNT_LAST);
    assign word_now = {sr[DATA_W-2:0], sdata_s2};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            cnt       <= '0;
            chan      <= 1'b0;
            sr        <= '0;
            lrck_prev <= 1'b0;
            lr_seen   <= 1'b0;
        end else begin
            if (rise) begin
                lrck_prev <= lrck_s2;
                lr_seen   <= 1'b1;
            end
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (rise) begin
                unique case (state)
                    IDLE: begin
                        if (ws_chg) begin
                            state <= SHIFT;
                            cnt   <= '0;
                            chan  <= lrck_s2;
                        end
                    end
                    SHIFT: begin
                        if (cnt < CNT_FULL) begin
                            sr  <= word_now;
                            cnt <= cnt + CW'(1);
                        end
                        // The ws-change bit is the previous slot's LSB, so
                        // the shift above happens before the restart.
                        if (ws_chg) begin
                            cnt  <= '0;
                            chan <= lrck_s2;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              pop, push_ok, ovr_now;
    logic [LW-1:0]     level_nxt;

    assign pop     = rdreq & ~empty;
    assign push_ok = push_now & (~full | pop);
    assign ovr_now = push_now & full & ~pop;

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push_ok)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge pclk) begin
        if (push_ok)
            mem[wr_ptr] <= {chan, word_now};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rchan     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr][DATA_W-1:0];
                rchan  <= mem[rd_ptr][DATA_W];
            end
            rvalid    <= pop;
            level     <= level_nxt;
            empty     <= (level_nxt == '0);
            full      <= (level_nxt == LW'(FIFO_DEPTH));
            overrun   <= ovr_now | (overrun & ~clr_err);
            frame_err <= ferr_now | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_iis_receiver.sv
// Directed testbench for iis_receiver: I2S frames driven at bclk = pclk/8,
// checked against hand-computed words, channels, levels and flags.
module tb_iis_receiver;

    logic        pclk;
    logic        presetn;
    logic        enable;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic        rdreq;
    logic [15:0] rdata;
    logic        rchan;
    logic        rvalid;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic        overrun;
    logic        frame_err;
    logic        clr_err;

    int n_tests;
    int n_fail;

    iis_receiver #(
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .enable    (enable),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdata     (sdata),
        .rdreq     (rdreq),
        .rdata     (rdata),
        .rchan     (rchan),
        .rvalid    (rvalid),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        bclk    = 1'b0;
        lrck    = 1'b0;
        sdata   = 1'b0;
        rdreq   = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    // One bclk period: low 4 pclk, high 4 pclk. With pop set, rdreq is
    // high exactly on the pclk edge where this bit's rise takes effect.
    task automatic bit_out(input logic lr, input logic d, input logic pop);
        bclk  = 1'b0;
        lrck  = lr;
        sdata = d;
        repeat (4) @(posedge pclk);
        #1 bclk = 1'b1;
        repeat (2) @(posedge pclk);
        #1 rdreq = pop;
        @(posedge pclk);
        #1 rdreq = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    // I2S slot of n bits: MSB..bit1 with lrck = lr, LSB one bclk later
    // with lrck already at the next channel.
    task automatic send_slot(input logic lr, input logic [31:0] w,
                             input int n, input logic nxt,
                             input logic pop_last);
        for (int k = n - 1; k >= 1; k--)
            bit_out(lr, w[k], 1'b0);
        bit_out(nxt, w[0], pop_last);
    endtask

    // Prime lrck history at 1, then a ws change into the left slot.
    task automatic preamble();
        bit_out(1'b1, 1'b0, 1'b0);
        bit_out(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input string tag, input logic ch,
                          input logic [15:0] d);
        rdreq = 1'b1;
        @(posedge pclk);
        #1 rdreq = 1'b0;
        chk({tag, "_rvalid"}, rvalid, 1);
        chk({tag, "_rchan"}, rchan, ch);
        chk({tag, "_rdata"}, rdata, d);
    endtask

    logic [15:0] wl [5];
    logic [31:0] v18;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        enable  = 1'b1;
        wl[0] = 16'h0001;
        wl[1] = 16'h8002;
        wl[2] = 16'h7FFE;
        wl[3] = 16'hC3C3;
        wl[4] = 16'h5A5A;

        // Reset state
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rchan", rchan, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);

        // Basic stereo frame
        preamble();
        send_slot(1'b0, 32'hA5C3, 16, 1'b1, 1'b0);
        send_slot(1'b1, 32'h1234, 16, 1'b0, 1'b0);
        chk("s1_level", level, 2);
        do_pop("s1_p0", 1'b0, 16'hA5C3);
        do_pop("s1_p1", 1'b1, 16'h1234);
        chk("s1_empty", empty, 1);
        chk("s1_ovr", overrun, 0);
        chk("s1_ferr", frame_err, 0);

        // Overrun with 5 words and no pops
        do_reset();
        preamble();
        for (int i = 0; i < 5; i++) begin
            send_slot(1'(i % 2), {16'h0, wl[i]}, 16, 1'(~(i % 2)), 1'b0);
            if (i == 3) begin
                chk("s2_full4", full, 1);
                chk("s2_ovr4", overrun, 0);
            end
        end
        chk("s2_level", level, 4);
        chk("s2_ovr", overrun, 1);
        for (int i = 0; i < 4; i++)
            do_pop($sformatf("s2_p%0d", i), 1'(i % 2), wl[i]);
        chk("s2_empty", empty, 1);
        clr_err = 1'b1;
        @(posedge pclk);
        #1 clr_err = 1'b0;
        chk("s2_clr", overrun, 0);

        // Short slot: frame error, next slot still good
        do_reset();
        preamble();
        send_slot(1'b0, 32'h3FF, 11, 1'b1, 1'b0);
        chk("s3_ferr", frame_err, 1);
        chk("s3_level0", level, 0);
        send_slot(1'b1, 32'hBEEF, 16, 1'b0, 1'b0);
        chk("s3_level1", level, 1);
        do_pop("s3_p", 1'b1, 16'hBEEF);

        // Full FIFO, push coinciding with pop
        do_reset();
        preamble();
        for (int i = 0; i < 4; i++)
            send_slot(1'(i % 2), {16'h0, wl[i]}, 16, 1'(~(i % 2)), 1'b0);
        chk("s4_full", full, 1);
        send_slot(1'b0, {16'h0, wl[4]}, 16, 1'b1, 1'b1);
        chk("s4_level", level, 4);
        chk("s4_ovr", overrun, 0);
        chk("s4_rdata", rdata, wl[0]);
        chk("s4_rchan", rchan, 0);
        for (int i = 1; i < 5; i++)
            do_pop($sformatf("s4_p%0d", i), 1'(i % 2), wl[i]);

        // Reset in the middle of a left word
        do_reset();
        preamble();
        repeat (7) bit_out(1'b0, 1'b1, 1'b0);
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        chk("s5_empty", empty, 1);
        chk("s5_level0", level, 0);
        repeat (8) bit_out(1'b0, 1'b1, 1'b0);
        bit_out(1'b1, 1'b1, 1'b0);
        chk("s5_nopush", level, 0);
        send_slot(1'b1, 32'h6D2E, 16, 1'b0, 1'b0);
        send_slot(1'b0, 32'h0F0F, 16, 1'b1, 1'b0);
        chk("s5_level2", level, 2);
        chk("s5_ferr", frame_err, 0);
        do_pop("s5_p0", 1'b1, 16'h6D2E);
        do_pop("s5_p1", 1'b0, 16'h0F0F);

        // Pop while empty, then an 18-bit slot
        do_reset();
        rdreq = 1'b1;
        @(posedge pclk);
        #1 rdreq = 1'b0;
        chk("s6_rvalid", rvalid, 0);
        chk("s6_level0", level, 0);
        chk("s6_empty", empty, 1);
        preamble();
        v18 = 32'h2B3C5;
        send_slot(1'b0, v18, 18, 1'b1, 1'b0);
        chk("s6_level1", level, 1);
        chk("s6_ferr", frame_err, 0);
        do_pop("s6_p", 1'b0, 16'hACF1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
